// File: rtl/decode_bundle_queue_pkg.sv
// ============================================================================
// Module   : decode_bundle_queue_pkg
// Brief    : Shared widths and entry format for the fetch-to-decode queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_bundle_queue_pkg;

  localparam int FETCH_WIDTH = 2;
  localparam int INSTBITS    = 32;
  localparam int DBITS       = 32;
  localparam int QUEUE_DEPTH = 4;
  localparam int ENTRY_W     = DBITS + FETCH_WIDTH + INSTBITS * FETCH_WIDTH;

  // Stored entry layout, PC in the most significant bits.
  typedef struct packed {
    logic [DBITS-1:0]                pc;
    logic [FETCH_WIDTH-1:0]          mask;
    logic [INSTBITS*FETCH_WIDTH-1:0] instrs;
  } bundle_t;

endpackage

`default_nettype wire

// File: rtl/decode_bundle_queue_storage.sv
// ============================================================================
// Module   : bundle_storage
// Brief    : DEPTH x entry register file, one sync write port, one async read.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bundle_storage
  import decode_bundle_queue_pkg::*;
#(
  parameter int DEPTH = QUEUE_DEPTH,
  parameter int WIDTH = ENTRY_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = r_mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/decode_bundle_queue.sv
// ============================================================================
// Module   : decode_bundle_queue
// Brief    : Circular bundle queue between fetch and decode with flush.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_bundle_queue
  import decode_bundle_queue_pkg::*;
#(
  parameter int DEPTH  = QUEUE_DEPTH,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            fe_valid,
  output logic                            fe_ready,
  input  logic [INSTBITS*FETCH_WIDTH-1:0] fe_instrs,
  input  logic [FETCH_WIDTH-1:0]          fe_mask,
  input  logic [DBITS-1:0]                fe_pc,
  output logic                            dec_valid,
  input  logic                            dec_ready,
  output logic [INSTBITS*FETCH_WIDTH-1:0] dec_instrs,
  output logic [FETCH_WIDTH-1:0]          dec_mask,
  output logic [DBITS-1:0]                dec_pc,
  input  logic                            flush,
  output logic [CNT_W-1:0]                count
);

  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(DEPTH);

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;
  logic             w_wr_en;
  bundle_t          w_wr_entry;
  bundle_t          w_rd_entry;

  // Ready/valid derive from registered occupancy only, so no dec_ready -> fe_ready path.
  assign fe_ready  = (r_count != C_FULL);
  assign dec_valid = (r_count != '0);
  assign count     = r_count;

  // Empty-mask bundles complete the handshake but are never stored.
  assign w_push  = fe_valid && fe_ready && (fe_mask != '0);
  assign w_pop   = dec_valid && dec_ready;
  assign w_wr_en = w_push && !flush;

  assign w_wr_entry = '{pc: fe_pc, mask: fe_mask, instrs: fe_instrs};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  bundle_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_storage (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (w_wr_en),
    .wr_addr (r_tail),
    .wr_data (w_wr_entry),
    .rd_addr (r_head),
    .rd_data (w_rd_entry)
  );

  assign dec_instrs = w_rd_entry.instrs;
  assign dec_pc     = w_rd_entry.pc;
  assign dec_mask   = dec_valid ? w_rd_entry.mask : '0;

endmodule

`default_nettype wire

// File: tb/tb_decode_bundle_queue.sv
// ============================================================================
// Module   : tb_decode_bundle_queue
// Brief    : Directed plus random checks of decode_bundle_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_bundle_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fe_valid;
  logic        fe_ready;
  logic [63:0] fe_instrs;
  logic [1:0]  fe_mask;
  logic [31:0] fe_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [63:0] dec_instrs;
  logic [1:0]  dec_mask;
  logic [31:0] dec_pc;
  logic        flush;
  logic [2:0]  count;

  int vectors    = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [1:0]  mask;
    logic [63:0] instrs;
  } ent_t;

  ent_t q[$];

  decode_bundle_queue #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .fe_valid   (fe_valid),
    .fe_ready   (fe_ready),
    .fe_instrs  (fe_instrs),
    .fe_mask    (fe_mask),
    .fe_pc      (fe_pc),
    .dec_valid  (dec_valid),
    .dec_ready  (dec_ready),
    .dec_instrs (dec_instrs),
    .dec_mask   (dec_mask),
    .dec_pc     (dec_pc),
    .flush      (flush),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("count", 64'(count), 64'(q.size()));
    chk("fe_ready", 64'(fe_ready), 64'(q.size() != 4));
    chk("dec_valid", 64'(dec_valid), 64'(q.size() != 0));
    if (q.size() != 0) begin
      chk("dec_pc", 64'(dec_pc), 64'(q[0].pc));
      chk("dec_mask", 64'(dec_mask), 64'(q[0].mask));
      chk("dec_instrs", dec_instrs, q[0].instrs);
    end else begin
      chk("dec_mask_empty", 64'(dec_mask), 64'd0);
    end
  endtask

  // Advance one clock with the currently driven inputs, update the model, then compare.
  task automatic cycle();
    int   sz;
    ent_t e;
    sz = q.size();
    @(posedge clk);
    if (flush) begin
      q.delete();
    end else begin
      if (fe_valid && sz < 4 && fe_mask != 2'b00) begin
        e.pc = fe_pc; e.mask = fe_mask; e.instrs = fe_instrs;
        q.push_back(e);
      end
      if (sz > 0 && dec_ready) void'(q.pop_front());
    end
    #1;
    check_model();
  endtask

  task automatic drive(input logic v, input logic [1:0] m, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    fe_valid  = v;
    fe_mask   = m;
    fe_pc     = pc;
    fe_instrs = {$urandom(), $urandom()};
    dec_ready = rdy;
    flush     = fl;
  endtask

  initial begin
    rst = 1'b0;
    fe_valid = 1'b0; fe_mask = '0; fe_pc = '0; fe_instrs = '0;
    dec_ready = 1'b0; flush = 1'b0;

    #12;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_fe_ready", 64'(fe_ready), 64'd1);
    chk("rst_dec_mask", 64'(dec_mask), 64'd0);
    chk("rst_dec_pc", 64'(dec_pc), 64'd0);
    chk("rst_dec_instrs", dec_instrs, 64'd0);
    #10 rst = 1'b1;
    @(posedge clk); #1;

    // Single bundle
    drive(1, 2'b11, 32'h100, 0, 0);
    fe_instrs = {32'h00208033, 32'h00500093};
    cycle();
    chk("single_pc", 64'(dec_pc), 64'h100);
    chk("single_instrs", dec_instrs, {32'h00208033, 32'h00500093});
    drive(0, 2'b00, 0, 1, 0);
    cycle();
    chk("single_drained", 64'(dec_valid), 64'd0);

    // Fill and backpressure
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'b11, 32'h100 + 32'(i) * 32'h10, 0, 0);
      cycle();
    end
    chk("full_fe_ready", 64'(fe_ready), 64'd0);
    chk("full_count", 64'(count), 64'd4);

    // Full with simultaneous pop: pop only, then push+pop
    drive(1, 2'b01, 32'h140, 1, 0);
    cycle();
    chk("full_pop_count", 64'(count), 64'd3);
    cycle();
    chk("pushpop_count", 64'(count), 64'd3);
    drive(0, 2'b00, 0, 1, 0);
    repeat (4) cycle();

    // Pointer wrap at count=1
    drive(1, 2'b10, 32'h300, 0, 0);
    cycle();
    for (int i = 1; i <= 10; i++) begin
      drive(1, 2'b11, 32'h300 + 32'(i) * 32'h4, 1, 0);
      cycle();
      chk("wrap_count", 64'(count), 64'd1);
    end
    drive(0, 2'b00, 0, 1, 0);
    cycle();

    // Empty mask is dropped
    drive(1, 2'b00, 32'h180, 0, 0);
    cycle();
    chk("empty_mask_valid", 64'(dec_valid), 64'd0);

    // Flush with simultaneous push
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b11, 32'h1c0 + 32'(i) * 32'h8, 0, 0);
      cycle();
    end
    drive(1, 2'b11, 32'h200, 1, 1);
    cycle();
    chk("flush_count", 64'(count), 64'd0);
    cycle();
    chk("flush2_fe_ready", 64'(fe_ready), 64'd1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)), $urandom(),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 15) == 0));
      cycle();
    end

    // Async reset mid-drain
    for (int i = 0; i < 3; i++) begin
      drive(1, 2'b11, 32'h400 + 32'(i) * 32'h10, 0, 0);
      cycle();
    end
    drive(0, 2'b00, 0, 1, 0);
    cycle();
    #2 rst = 1'b0;
    #1;
    q.delete();
    chk("async_rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("async_rst_fe_ready", 64'(fe_ready), 64'd1);
    chk("async_rst_count", 64'(count), 64'd0);
    chk("async_rst_dec_pc", 64'(dec_pc), 64'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    drive(1, 2'b01, 32'h500, 0, 0);
    cycle();
    drive(0, 2'b00, 0, 1, 0);
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
